// File: rtl/pid_sched_if.sv
// pid_sched_if: sample/result bundle for pid_sched.
//   error       signed raw error sample (12b)
//   err_in_vld  one-cycle strobe, error valid
//   clr_hist    synchronous clear of integrator and previous error
//   busy        high while a sample is in flight
//   ovr         one-cycle pulse, a sample was dropped
//   pid         signed saturated PID result (14b)
//   pid_vld     one-cycle strobe, pid updated
// master = error source side, slave = pid_sched.
interface pid_sched_if;
  logic signed [11:0] error;
  logic               err_in_vld;
  logic               clr_hist;
  logic               busy;
  logic               ovr;
  logic signed [13:0] pid;
  logic               pid_vld;

  modport master (
    output error, err_in_vld, clr_hist,
    input  busy, ovr, pid, pid_vld
  );

  modport slave (
    input  error, err_in_vld, clr_hist,
    output busy, ovr, pid, pid_vld
  );
endinterface

// File: rtl/pid_sched.sv
// pid_sched: PID term sequencer for the balance control loop.
// Saturates each raw error sample to 10 bits, time-shares one signed
// multiplier between the P and D terms, keeps the integrator and the
// previous-error history, and emits one saturated 14-bit PID result
// per accepted sample (one sample per 4 cycles at most).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pid_sched_if.slave (error/err_in_vld/clr_hist in,
//          busy/ovr/pid/pid_vld out)
// Parameters:
//   P_COEFF, D_COEFF  unsigned 5-bit coefficients
module pid_sched #(
  parameter logic [4:0] P_COEFF = 5'd4,
  parameter logic [4:0] D_COEFF = 5'd7
) (
  input logic        clk,
  input logic        rst_n,
  pid_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_P, MUL_D, SUM} state_t;

  state_t             state;
  logic signed [9:0]  err_q;     // captured, saturated sample
  logic signed [9:0]  prev_err;
  logic signed [15:0] integ;
  logic signed [13:0] p_term;
  logic signed [12:0] d_term;

  // ---------------------------------------------------------------
  // Input saturation to 10-bit signed
  // ---------------------------------------------------------------
  logic signed [9:0] err_sat_in;
  always_comb begin
    err_sat_in = bus.error[9:0];
    if (!bus.error[11] && (|bus.error[10:9]))
      err_sat_in = 10'sd511;
    else if (bus.error[11] && !(&bus.error[10:9]))
      err_sat_in = -10'sd512;
  end

  // ---------------------------------------------------------------
  // Derivative difference, saturated to 8-bit signed
  // ---------------------------------------------------------------
  logic signed [10:0] d_diff;
  logic signed [7:0]  d_sat;
  assign d_diff = {err_q[9], err_q} - {prev_err[9], prev_err};
  always_comb begin
    d_sat = d_diff[7:0];
    if (!d_diff[10] && (|d_diff[9:7]))
      d_sat = 8'sd127;
    else if (d_diff[10] && !(&d_diff[9:7]))
      d_sat = -8'sd128;
  end

  // ---------------------------------------------------------------
  // Shared multiplier: operand and coefficient muxed by state.
  // Coefficient is zero-extended so it is always non-negative.
  // ---------------------------------------------------------------
  logic signed [9:0]  mul_a;
  logic        [4:0]  mul_c;
  logic signed [15:0] mul_a16;
  logic signed [15:0] mul_b16;
  logic signed [15:0] product;

  always_comb begin
    mul_a = err_q;
    mul_c = P_COEFF;
    if (state == MUL_D) begin
      mul_a = {{2{d_sat[7]}}, d_sat};
      mul_c = D_COEFF;
    end
  end

  assign mul_a16 = {{6{mul_a[9]}}, mul_a};
  assign mul_b16 = {11'b0, mul_c};
  assign product = mul_a16 * mul_b16;

  // P term: product saturated to 14-bit signed
  logic signed [13:0] p_sat;
  always_comb begin
    p_sat = product[13:0];
    if (!product[15] && (|product[14:13]))
      p_sat = 14'sd8191;
    else if (product[15] && !(&product[14:13]))
      p_sat = -14'sd8192;
  end

  // ---------------------------------------------------------------
  // Integrator update, clamped (never wraps)
  // ---------------------------------------------------------------
  logic signed [16:0] integ_sum;
  logic signed [15:0] integ_nxt;
  assign integ_sum = {integ[15], integ} + {{7{err_q[9]}}, err_q};
  always_comb begin
    integ_nxt = integ_sum[15:0];
    if (integ_sum[16] != integ_sum[15])
      integ_nxt = integ_sum[16] ? 16'sh8000 : 16'sh7FFF;
  end

  // ---------------------------------------------------------------
  // Final sum: P + (integ >>> 4) + D, saturated to 14-bit signed.
  // Worst-case magnitude (8192+2048+3968) fits in 16 bits.
  // ---------------------------------------------------------------
  logic signed [11:0] i_term;
  logic signed [15:0] sum;
  logic signed [13:0] sum_sat;
  assign i_term = integ[15:4];
  assign sum = {{2{p_term[13]}}, p_term}
             + {{4{i_term[11]}}, i_term}
             + {{3{d_term[12]}}, d_term};
  always_comb begin
    sum_sat = sum[13:0];
    if (!sum[15] && (|sum[14:13]))
      sum_sat = 14'sd8191;
    else if (sum[15] && !(&sum[14:13]))
      sum_sat = -14'sd8192;
  end

  assign bus.busy = (state != IDLE);

  // ---------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      err_q       <= '0;
      prev_err    <= '0;
      integ       <= '0;
      p_term      <= '0;
      d_term      <= '0;
      bus.pid     <= '0;
      bus.pid_vld <= 1'b0;
      bus.ovr     <= 1'b0;
    end else begin
      bus.pid_vld <= 1'b0;
      // Samples arriving mid-flight are dropped and flagged
      bus.ovr     <= bus.err_in_vld && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.err_in_vld) begin
            err_q <= err_sat_in;
            state <= MUL_P;
          end
        end
        MUL_P: begin
          p_term <= p_sat;
          integ  <= integ_nxt;
          state  <= MUL_D;
        end
        MUL_D: begin
          d_term   <= product[12:0];  // |sat8 * 31| < 4096, fits 13b
          prev_err <= err_q;
          state    <= SUM;
        end
        SUM: begin
          bus.pid     <= sum_sat;
          bus.pid_vld <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // History clear overrides any same-edge history update
      if (bus.clr_hist) begin
        integ    <= '0;
        prev_err <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pid_sched.sv
module tb_pid_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  pid_sched_if bus();
  pid_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.err_in_vld = 1'b0;
    bus.clr_hist   = 1'b0;
    bus.error      = '0;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Drive one sample and watch 8 cycles: latency (ticks after accept
  // to pid_vld visible), busy cycle count, number of pid_vld pulses.
  task automatic run_sample(input logic signed [11:0] e, output int lat,
                            output int bcyc, output int nvld);
    bus.error = e;
    bus.err_in_vld = 1'b1;
    tick;
    bus.err_in_vld = 1'b0;
    lat = -1; bcyc = 0; nvld = 0;
    for (int i = 1; i <= 8; i++) begin
      if (bus.busy) bcyc++;
      tick;
      if (bus.pid_vld) begin
        nvld++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset;
    int nv;
    rst_n = 1'b0;
    bus.clr_hist = 1'b0;
    bus.error = 12'sd100;
    bus.err_in_vld = 1'b1;
    repeat (3) tick;
    total++; if (bus.pid !== 14'sd0) begin bad++; $display("FAIL reset_pid: got %0d want 0", bus.pid); end
    total++; if (bus.pid_vld !== 1'b0) begin bad++; $display("FAIL reset_pid_vld: got %b want 0", bus.pid_vld); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.ovr); end
    bus.err_in_vld = 1'b0;
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.pid_vld || bus.busy) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL reset_no_response: got %0d activity cycles want 0", nv); end
  endtask

  task automatic test_single;
    int lat, bc, nv;
    do_reset;
    run_sample(12'sd100, lat, bc, nv);
    total++; if (lat !== 3) begin bad++; $display("FAIL single_latency: got %0d want 3", lat); end
    total++; if (bc !== 3) begin bad++; $display("FAIL single_busy_cycles: got %0d want 3", bc); end
    total++; if (nv !== 1) begin bad++; $display("FAIL single_vld_count: got %0d want 1", nv); end
    total++; if (bus.pid !== 14'sd1106) begin bad++; $display("FAIL single_pid: got %0d want 1106", bus.pid); end
  endtask

  task automatic test_extremes;
    int lat, bc, nv;
    do_reset;
    run_sample(12'sd2047, lat, bc, nv);
    total++; if (bus.pid !== 14'sd2964) begin bad++; $display("FAIL ext_pos_pid: got %0d want 2964", bus.pid); end
    run_sample(-12'sd2048, lat, bc, nv);
    total++; if (bus.pid !== -14'sd2945) begin bad++; $display("FAIL ext_neg_pid: got %0d want -2945", bus.pid); end
    total++; if (dut.integ !== -16'sd1) begin bad++; $display("FAIL ext_integ: got %0d want -1", dut.integ); end
  endtask

  task automatic test_overrun;
    int novr, nv;
    do_reset;
    bus.error = 12'sd100;
    bus.err_in_vld = 1'b1;
    tick;                      // accepted
    bus.error = 12'sd500;      // still strobing: dropped
    tick;
    bus.err_in_vld = 1'b0;
    novr = bus.ovr ? 1 : 0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.ovr) novr++;
      if (bus.pid_vld) nv++;
    end
    total++; if (novr !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", novr); end
    total++; if (nv !== 1) begin bad++; $display("FAIL ovr_vld_count: got %0d want 1", nv); end
    total++; if (bus.pid !== 14'sd1106) begin bad++; $display("FAIL ovr_pid: got %0d want 1106", bus.pid); end
    total++; if (dut.integ !== 16'sd100) begin bad++; $display("FAIL ovr_integ: got %0d want 100", dut.integ); end
  endtask

  task automatic test_clamp;
    int lat, bc, nv;
    do_reset;
    for (int n = 1; n <= 70; n++) begin
      run_sample(12'sd511, lat, bc, nv);
      if (n == 64) begin
        total++; if (dut.integ !== 16'sd32704) begin bad++; $display("FAIL clamp_integ64: got %0d want 32704", dut.integ); end
      end
      if (n == 65) begin
        total++; if (dut.integ !== 16'sd32767) begin bad++; $display("FAIL clamp_integ65: got %0d want 32767", dut.integ); end
      end
    end
    total++; if (dut.integ !== 16'sd32767) begin bad++; $display("FAIL clamp_integ70: got %0d want 32767", dut.integ); end
    total++; if (bus.pid !== 14'sd4091) begin bad++; $display("FAIL clamp_pid: got %0d want 4091", bus.pid); end
  endtask

  task automatic test_clear;
    int lat, bc, nv;
    do_reset;
    for (int n = 0; n < 10; n++) run_sample(12'sd100, lat, bc, nv);
    total++; if (dut.integ !== 16'sd1000) begin bad++; $display("FAIL clr_pre_integ: got %0d want 1000", dut.integ); end
    // Clear on the MUL_P edge: clear beats integ update, prev_err cleared
    // before MUL_D, so P=400, I=0, D=700.
    bus.error = 12'sd100;
    bus.err_in_vld = 1'b1;
    tick;
    bus.err_in_vld = 1'b0;
    bus.clr_hist = 1'b1;
    tick;
    bus.clr_hist = 1'b0;
    repeat (6) tick;
    total++; if (bus.pid !== 14'sd1100) begin bad++; $display("FAIL clr_inflight_pid: got %0d want 1100", bus.pid); end
    total++; if (dut.integ !== 16'sd0) begin bad++; $display("FAIL clr_inflight_integ: got %0d want 0", dut.integ); end
    // Idle clear then a fresh sample behaves as from reset
    bus.clr_hist = 1'b1;
    tick;
    bus.clr_hist = 1'b0;
    run_sample(12'sd100, lat, bc, nv);
    total++; if (bus.pid !== 14'sd1106) begin bad++; $display("FAIL clr_idle_pid: got %0d want 1106", bus.pid); end
    total++; if (dut.integ !== 16'sd100) begin bad++; $display("FAIL clr_idle_integ: got %0d want 100", dut.integ); end
  endtask

  task automatic test_reset_mid;
    int nv;
    bus.error = 12'sd300;
    bus.err_in_vld = 1'b1;
    tick;                      // accepted
    bus.err_in_vld = 1'b0;
    tick;                      // now in MUL_D
    rst_n = 1'b0;
    #1;
    total++; if (bus.pid !== 14'sd0) begin bad++; $display("FAIL rmid_pid: got %0d want 0", bus.pid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    total++; if (bus.pid_vld !== 1'b0 || bus.ovr !== 1'b0) begin bad++; $display("FAIL rmid_strobes: got vld=%b ovr=%b want 0 0", bus.pid_vld, bus.ovr); end
    total++; if (dut.integ !== 16'sd0) begin bad++; $display("FAIL rmid_integ: got %0d want 0", dut.integ); end
    tick;
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.pid_vld) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL rmid_no_vld: got %0d want 0", nv); end
    total++; if (bus.pid !== 14'sd0) begin bad++; $display("FAIL rmid_pid_after: got %0d want 0", bus.pid); end
  endtask

  initial begin
    bus.error = '0;
    bus.err_in_vld = 1'b0;
    bus.clr_hist = 1'b0;
    test_reset;
    test_single;
    test_extremes;
    test_overrun;
    test_clamp;
    test_clear;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
